tdm_mux4: RTL and testbench



---
 rtl/tdm_mux4.sv | 124 ++++++++++++
 tb/tb_tdm_mux4.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/tdm_mux4.sv
// ---------------------------------------------------------------------------
// tdm_mux4 -- four-channel time-division multiplexer
//
// Merges four valid/ready input streams into one tagged output stream.
// Arbitration is round-robin. The scan starts at the pointer and the pointer
// moves to one past the winner on every accepted beat. A single output
// register holds the beat. It can be reloaded in the same cycle that it is
// drained, so a continuously ready consumer sees one beat per cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   [3:0]  per-channel beat present
//   in_ready   [3:0]  per-channel beat accepted this cycle (one-hot or zero)
//   in0..in3   [W-1:0] channel payloads
//   out_valid         output register holds a beat
//   out_ready         downstream accepts the held beat
//   out_data  [W-1:0] payload of the held beat
//   out_sel   [1:0]   source channel of the held beat
// ---------------------------------------------------------------------------
module tdm_mux4 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel
);

  // Registered state
  logic [1:0]   ptr_q,       ptr_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic [1:0]   out_sel_q,   out_sel_d;

  // Arbitration
  logic [W-1:0] in_data [4];
  logic [1:0]   grant;
  logic         any_req;
  logic         can_load;
  logic         in_hs;
  logic         out_hs;

  // Gather the payload ports into an array so the winner selects by index.
  assign in_data[0] = in0;
  assign in_data[1] = in1;
  assign in_data[2] = in2;
  assign in_data[3] = in3;

  // The register can take a new beat when it is empty or being drained now.
  assign can_load = !out_valid_q || out_ready;

  // Round-robin search over ptr, ptr+1, ptr+2, ptr+3. The 2-bit index sum
  // wraps modulo 4. The first requester wins.
  always_comb begin
    logic [1:0] idx;
    grant   = ptr_q;
    any_req = 1'b0;
    idx     = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!any_req && in_valid[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

  // in_ready is forced low while reset is asserted. Without this, the empty
  // register would let the combinational grant show through during reset.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ready
      assign in_ready[gi] = rst_n && can_load && any_req &&
                            (grant == 2'(gi)) && in_valid[gi];
    end
  endgenerate

  assign in_hs  = |in_ready;
  assign out_hs = out_valid_q && out_ready;

  // Next-state logic. A new input beat takes priority over a simple drain,
  // so load and drain in the same cycle produce no bubble.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (in_hs) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[grant];
      out_sel_d   = grant;
      ptr_d       = grant + 2'd1;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_tdm_mux4.sv
module tb_tdm_mux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [7:0] in0, in1, in2, in3;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;

  int n_assert = 0;
  int n_fail   = 0;

  tdm_mux4 #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the whole output register: valid, sel, data.
  task automatic chk_out(input string tag, input logic v, input logic [1:0] s,
                         input logic [7:0] d);
    chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
    chk({tag, ".sel"},   {6'd0, out_sel},   {6'd0, s});
    chk({tag, ".data"},  out_data, d);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_sel;
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in0 = 8'h10; in1 = 8'h11; in2 = 8'h12; in3 = 8'h13;

    // Hold reset with every channel requesting.
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk_out("reset", 1'b0, 2'd0, 8'h00);
      chk("reset.in_ready", {4'd0, in_ready}, 8'h00);
    end

    // Release reset. The first grant goes to channel 0, then round-robin.
    rst_n = 1'b1;
    #1;
    chk("post_reset.in_ready", {4'd0, in_ready}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      exp_sel = 2'(i);
      edge_step();
      chk_out($sformatf("rr%0d", i), 1'b1, exp_sel, 8'h10 + 8'(exp_sel));
      $display("rr beat %0d: sel=%0d data=%h", i, out_sel, out_data);
    end

    // Only channel 2 requests.
    in_valid = 4'b0100;
    in2      = 8'hA5;
    #1;
    chk("single.in_ready", {4'd0, in_ready}, 8'h04);
    edge_step();
    chk_out("single", 1'b1, 2'd2, 8'hA5);
    $display("single beat: sel=%0d data=%h", out_sel, out_data);
    in_valid = 4'b0000;
    #1;
    chk("idle.in_ready", {4'd0, in_ready}, 8'h00);
    edge_step();
    chk_out("drain", 1'b0, 2'd2, 8'hA5);
    edge_step();
    // The pointer stays at 3 through idle cycles, so channel 3 wins first.
    in_valid = 4'b1111;
    #1;
    chk("ptr3.in_ready", {4'd0, in_ready}, 8'h08);

    // Load a beat from channel 1, then apply backpressure.
    in_valid = 4'b0010;
    in2      = 8'h12;
    #1;
    chk("ch1.in_ready", {4'd0, in_ready}, 8'h02);
    edge_step();
    chk_out("ch1", 1'b1, 2'd1, 8'h11);
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #1;
    chk("bp.in_ready", {4'd0, in_ready}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk_out($sformatf("bp%0d", i), 1'b1, 2'd1, 8'h11);
      chk($sformatf("bp%0d.in_ready", i), {4'd0, in_ready}, 8'h00);
      $display("backpressure cycle %0d: sel=%0d data=%h", i, out_sel, out_data);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", {4'd0, in_ready}, 8'h04);
    edge_step();
    chk_out("bp_release", 1'b1, 2'd2, 8'h12);

    // The pointer is 3 and only channels 0 and 1 request: skip 3, wrap to 0, then 1.
    in_valid = 4'b0011;
    #1;
    chk("wrap0.in_ready", {4'd0, in_ready}, 8'h01);
    edge_step();
    chk_out("wrap0", 1'b1, 2'd0, 8'h10);
    chk("wrap1.in_ready", {4'd0, in_ready}, 8'h02);
    edge_step();
    chk_out("wrap1", 1'b1, 2'd1, 8'h11);

    // Hold a beat from channel 3, then reset asynchronously mid-cycle.
    in_valid = 4'b1000;
    edge_step();
    chk_out("pre_rst", 1'b1, 2'd3, 8'h13);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 2'd0, 8'h00);
    chk("async_rst.in_ready", {4'd0, in_ready}, 8'h00);
    $display("async reset: valid=%0d sel=%0d data=%h", out_valid, out_sel, out_data);
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    edge_step();
    chk("rst_hold.in_ready", {4'd0, in_ready}, 8'h00);
    rst_n = 1'b1;
    #1;
    chk("rst_release.in_ready", {4'd0, in_ready}, 8'h01);
    edge_step();
    chk_out("rst_first", 1'b1, 2'd0, 8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
